// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and access sequencer for a single-port
// 16-bit main memory. Port 0 is the CPU and port 1 is the loader/DMA.
// One request is granted at a time. The address strobe and the data strobe
// are issued in separate cycles. The winner then gets a one-cycle acknowledge,
// plus read data when the access was a read.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN     port N request, direction, address, write data
//   ackN/rdataN               port N completion pulse and read data
//   mem_addr_en/mem_addr      address-latch strobe and address to memory
//   mem_in_en/mem_in          write strobe and write data to memory
//   mem_out_en/mem_out        read strobe to memory, registered read data back
//   busy/owner                sequencer active, port currently granted
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_addr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_in_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_out_en,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        ACK  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                grant_s;
    logic                any_req_s;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                owner_r;
    // Port granted most recently. It resets to 1 so that port 0 wins the first tie.
    logic                last_r;

    assign any_req_s = req0 | req1;

    // Winner selection for the current request pattern
    always_comb begin
        grant_s = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRI != 0) begin
                grant_s = 1'b0;
            end else begin
                grant_s = ~last_r;
            end
        end else if (req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (we_r) begin
                    state_s = WR;
                end else begin
                    state_s = RD;
                end
            end
            WR:      state_s = ACK;
            RD:      state_s = ACK;
            ACK:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Capture the winning request at the granting edge. Inputs are ignored afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            owner_r <= 1'b0;
            last_r  <= 1'b1;
        end else if (state_r == IDLE && any_req_s) begin
            owner_r <= grant_s;
            last_r  <= grant_s;
            we_r    <= grant_s ? we1 : we0;
            addr_r  <= grant_s ? addr1 : addr0;
            wdata_r <= grant_s ? wdata1 : wdata0;
        end
    end

    // Strobes and acknowledges decode from the state register only.
    // This gives half a cycle of setup before the falling edge where the memory samples them.
    always_comb begin
        mem_addr_en = 1'b0;
        mem_in_en   = 1'b0;
        mem_out_en  = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        rdata0      = {DATA_W{1'b0}};
        rdata1      = {DATA_W{1'b0}};
        case (state_r)
            ADDR: mem_addr_en = 1'b1;
            WR:   mem_in_en   = 1'b1;
            RD:   mem_out_en  = 1'b1;
            ACK: begin
                if (owner_r) begin
                    ack1 = 1'b1;
                    if (!we_r) begin
                        rdata1 = mem_out;
                    end else begin
                        rdata1 = {DATA_W{1'b0}};
                    end
                end else begin
                    ack0 = 1'b1;
                    if (!we_r) begin
                        rdata0 = mem_out;
                    end else begin
                        rdata0 = {DATA_W{1'b0}};
                    end
                end
            end
            default: begin
                mem_addr_en = 1'b0;
            end
        endcase
    end

    assign mem_addr = addr_r;
    assign mem_in   = wdata_r;
    assign busy     = (state_r != IDLE);
    assign owner    = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It runs a round-robin instance (dut),
// with a scoreboard on its acknowledges, and a fixed-priority instance (fdut).
// Each instance has its own behavioural memory. Each memory latches the
// address and performs writes on the falling edge, and loads read data on the
// rising edge. Its output reads 16'hDEAD when the read strobe was low.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;

    logic        ack0, ack1, mem_addr_en, mem_in_en, mem_out_en, busy, owner;
    logic [15:0] rdata0, rdata1, mem_addr, mem_in, mem_out;
    logic        f_ack0, f_ack1, f_addr_en, f_in_en, f_out_en, f_busy, f_owner;
    logic [15:0] f_rdata0, f_rdata1, f_addr, f_in, f_out;

    logic [15:0] mem_a [0:255];
    logic [15:0] areg_a;
    logic [15:0] mem_f [0:255];
    logic [15:0] areg_f;

    typedef struct {
        logic        port;
        logic [15:0] rdata;
    } exp_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   sb_on   = 1'b1;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRI(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_addr_en(mem_addr_en), .mem_addr(mem_addr), .mem_in_en(mem_in_en), .mem_in(mem_in),
        .mem_out_en(mem_out_en), .mem_out(mem_out), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRI(1)) fdut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(f_ack0), .rdata0(f_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(f_ack1), .rdata1(f_rdata1),
        .mem_addr_en(f_addr_en), .mem_addr(f_addr), .mem_in_en(f_in_en), .mem_in(f_in),
        .mem_out_en(f_out_en), .mem_out(f_out), .busy(f_busy), .owner(f_owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure the spacing between acknowledges
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: address latch and write on the falling edge
    always @(negedge clk) begin
        if (mem_addr_en) areg_a <= mem_addr;
        if (mem_in_en)   mem_a[areg_a[7:0]] <= mem_in;
        if (f_addr_en)   areg_f <= f_addr;
        if (f_in_en)     mem_f[areg_f[7:0]] <= f_in;
    end

    // Memory models: read data is loaded on the rising edge, and reads garbage when not strobed
    always @(posedge clk) begin
        mem_out <= mem_out_en ? mem_a[areg_a[7:0]] : 16'hDEAD;
        f_out   <= f_out_en   ? mem_f[areg_f[7:0]] : 16'hDEAD;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every acknowledge of the round-robin instance must match the oldest expectation
    always @(negedge clk) begin
        if (sb_on && rst && (ack0 || ack1)) begin
            check("single_ack", {31'd0, ack0 & ack1}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                check("rdata_owner", {16'd0, (e.port ? rdata1 : rdata0)}, {16'd0, e.rdata});
                check("rdata_other", {16'd0, (e.port ? rdata0 : rdata1)}, 32'd0);
            end
        end
    end

    task automatic wait_ack(input logic p);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (p ? ack1 : ack0) seen = 1'b1;
        end
        check(p ? "ack1_seen" : "ack0_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic drive(input logic p, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        e.port  = v.port;
        e.rdata = v.exp_rdata;
        sb_q.push_back(e);
        drive(v.port, v.we, v.addr, v.wdata);
        wait_ack(v.port);
        @(posedge clk);
        #1;
        if (v.port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   prev;
        int   n;
        bit   seen;
        bit   fp_bad;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h00FF, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b1, 16'h0040, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5A5};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_f[i] = 16'h0000;
        end
        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000;

        // Reset state
        #2;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        check("rst_strobes", {29'd0, mem_addr_en, mem_in_en, mem_out_en}, 32'd0);
        check("rst_acks",  {30'd0, ack0, ack1}, 32'd0);
        check("rst_addr",  {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First write with cycle-exact strobe timing
        @(posedge clk);
        #1;
        e.port = 1'b0; e.rdata = 16'h0000;
        sb_q.push_back(e);
        drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        @(posedge clk);
        @(negedge clk);
        check("c1_addr_en", {31'd0, mem_addr_en}, 32'd1);
        check("c1_addr",    {16'd0, mem_addr}, 32'h0010);
        check("c1_in_en",   {31'd0, mem_in_en}, 32'd0);
        check("c1_busy",    {30'd0, busy, owner}, 32'd2);
        @(negedge clk);
        check("c2_in_en",   {30'd0, mem_in_en, mem_addr_en}, 32'd2);
        check("c2_in",      {16'd0, mem_in}, 32'h0000BEEF);
        @(negedge clk);
        check("c3_ack0",    {31'd0, ack0}, 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;

        // Table of single-port transactions
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // The requester changes its inputs while the write is in service
        @(posedge clk);
        #1;
        e.port = 1'b0; e.rdata = 16'h0000;
        sb_q.push_back(e);
        drive(1'b0, 1'b1, 16'h0030, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        addr0 = 16'h0020;
        wdata0 = 16'hFFFF;
        check("wr_in_latched", {16'd0, mem_in}, 32'h00005555);
        wait_ack(1'b0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        run_txn('{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5555});
        run_txn('{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000});

        // Round-robin tie: port 0 was granted last, so the grants go 1,0,1,0
        @(posedge clk);
        #1;
        e.port = 1'b1; e.rdata = 16'h1234; sb_q.push_back(e);
        e.port = 1'b0; e.rdata = 16'hBEEF; sb_q.push_back(e);
        e.port = 1'b1; e.rdata = 16'h1234; sb_q.push_back(e);
        e.port = 1'b0; e.rdata = 16'hBEEF; sb_q.push_back(e);
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b0, 16'h00FF, 16'h0000);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 30) begin
                @(negedge clk);
                n++;
                if (ack0 || ack1) seen = 1'b1;
            end
            check("rr_ack_seen", {31'd0, seen}, 32'd1);
            if (k > 0) check("rr_spacing", cyc - prev, 32'd4);
            prev = cyc;
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset in the middle of a read
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'h00FF, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_rd_state", {31'd0, mem_out_en}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_busy",    {30'd0, busy, owner}, 32'd0);
        check("mid_strobes", {29'd0, mem_addr_en, mem_in_en, mem_out_en}, 32'd0);
        check("mid_acks",    {30'd0, ack0, ack1}, 32'd0);
        check("mid_addr",    {16'd0, mem_addr}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        e.port = 1'b0; e.rdata = 16'hBEEF; sb_q.push_back(e);
        e.port = 1'b1; e.rdata = 16'h1234; sb_q.push_back(e);
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        rst = 1'b1;
        wait_ack(1'b0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_ack(1'b1);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        check("sb_drain", sb_q.size(), 32'd0);

        // Fixed priority: port 0 is served repeatedly while port 1 waits
        sb_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b0, 16'h00FF, 16'h0000);
        fp_bad = 1'b0;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 30) begin
                @(negedge clk);
                n++;
                if (f_ack1) fp_bad = 1'b1;
                if (f_ack0) seen = 1'b1;
            end
            check("fp_ack0_seen", {31'd0, seen}, 32'd1);
            check("fp_rdata0", {16'd0, f_rdata0}, 32'h0000BEEF);
            if (k > 0) check("fp_spacing", cyc - prev, 32'd4);
            prev = cyc;
        end
        check("fp_no_ack1", {31'd0, fp_bad}, 32'd0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (f_ack1) seen = 1'b1;
        end
        check("fp_ack1_seen", {31'd0, seen}, 32'd1);
        check("fp_ack1_wait", n, 32'd4);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
